// File: rtl/viterbi_frame_ctrl_if.sv
// Signal bundle between the frame controller and the encoder/channel/decoder link.
// Handshake: every *_en / *_valid strobe qualifies the data beside it on the same
// rising clk edge. There is no backpressure; a strobe is consumed the cycle it is high.
interface viterbi_frame_ctrl_if;
   logic        start_i;
   logic [1:0]  err_mask_i;
   logic        enc_en_o;
   logic        enc_bit_o;
   logic        enc_valid_i;
   logic [1:0]  enc_sym_i;
   logic        dec_en_o;
   logic [1:0]  ch_sym_o;
   logic        dec_bit_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] chan_err_cnt_o;
   logic [15:0] bit_err_cnt_o;
   logic [15:0] frame_cnt_o;
   logic [2:0]  state_dbg;

   modport master (
      input  start_i, err_mask_i, enc_valid_i, enc_sym_i, dec_bit_i,
      output enc_en_o, enc_bit_o, dec_en_o, ch_sym_o, busy_o, done_o,
             chan_err_cnt_o, bit_err_cnt_o, frame_cnt_o, state_dbg
   );

   modport slave (
      output start_i, err_mask_i, enc_valid_i, enc_sym_i, dec_bit_i,
      input  enc_en_o, enc_bit_o, dec_en_o, ch_sym_o, busy_o, done_o,
             chan_err_cnt_o, bit_err_cnt_o, frame_cnt_o, state_dbg
   );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for encoder -> channel -> Viterbi decoder: PRBS data, zero tail,
// scheduled symbol corruption, and decoded-bit checking with error counters.
module viterbi_frame_ctrl #(
   parameter int          FRAME_LEN = 64,
   parameter int          TAIL_LEN  = 2,
   parameter int          DEC_LAT   = 10,
   parameter int          N         = 6,
   parameter int          BURST     = 1,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input logic                  clk,
   input logic                  rst,
   viterbi_frame_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DATA  = 3'd1,
      S_TAIL  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int          FIFO_DEPTH = 8;
   localparam int          FIFO_AW    = 3;
   localparam int          INJ_THR    = (1 << N) - BURST;
   localparam logic [15:0] DATA_LAST  = 16'(FRAME_LEN - 1);
   localparam logic [15:0] TAIL_LAST  = 16'((TAIL_LEN > 0) ? (TAIL_LEN - 1) : 0);

   state_t             state, state_nx;
   logic [15:0]        phase_cnt;
   logic [15:0]        lfsr;
   logic [15:0]        icnt;
   logic [15:0]        chan_cnt, bit_cnt, frame_cnt;
   logic               dec_en;
   logic [1:0]         ch_sym;
   logic [1:0]         fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   fifo_cnt;
   logic [2:0]         dline [DEC_LAT];

   logic               start_go, phase_last, enc_en, enc_bit, is_data;
   logic               do_push, do_pop, dl_busy, drain_idle, inj, bit_err;
   logic [1:0]         fifo_head, pop_cnt;
   logic [2:0]         dl_in, dl_out;
   logic [16:0]        chan_sum;

   // Next-state and Moore outputs of the frame sequencer
   always_comb begin
      state_nx   = state;
      enc_en     = 1'b0;
      enc_bit    = 1'b0;
      is_data    = 1'b0;
      start_go   = 1'b0;
      phase_last = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start_i) begin
               start_go = 1'b1;
               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            enc_en  = 1'b1;
            enc_bit = lfsr[0];
            is_data = 1'b1;
            if (phase_cnt == DATA_LAST) begin
               phase_last = 1'b1;
               state_nx   = (TAIL_LEN > 0) ? S_TAIL : S_DRAIN;
            end
         end
         S_TAIL: begin
            enc_en = 1'b1;
            if (phase_cnt == TAIL_LAST) begin
               phase_last = 1'b1;
               state_nx   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_idle) state_nx = S_DONE;
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register and per-phase cycle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         phase_cnt <= '0;
      end else begin
         state <= state_nx;
         if (enc_en && !phase_last) phase_cnt <= phase_cnt + 16'd1;
         else                       phase_cnt <= '0;
      end
   end

   // PRBS source: steps only while data bits are being sent, never reloaded per frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 lfsr <= SEED;
      else if (state == S_DATA) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign pop_cnt  = {1'b0, bus.err_mask_i[0]} + {1'b0, bus.err_mask_i[1]};
   assign chan_sum = {1'b0, chan_cnt} + {15'd0, pop_cnt};
   assign inj      = bus.enc_valid_i && (32'(icnt[N-1:0]) >= 32'(INJ_THR));

   // Channel register with periodic error injection and channel error count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dec_en   <= 1'b0;
         ch_sym   <= 2'b00;
         icnt     <= '0;
         chan_cnt <= '0;
      end else begin
         dec_en <= bus.enc_valid_i;
         ch_sym <= bus.enc_valid_i ? (bus.enc_sym_i ^ (inj ? bus.err_mask_i : 2'b00)) : 2'b00;
         if (start_go) begin
            icnt     <= '0;
            chan_cnt <= '0;
         end else begin
            if (bus.enc_valid_i) icnt <= icnt + 16'd1;
            if (inj) chan_cnt <= chan_sum[16] ? 16'hFFFF : chan_sum[15:0];
         end
      end
   end

   assign do_push   = enc_en && (fifo_cnt != (FIFO_AW+1)'(FIFO_DEPTH));
   assign do_pop    = dec_en && (fifo_cnt != '0);
   assign fifo_head = fifo_mem[rd_ptr];

   // Sent-bit FIFO {is_data, bit}: pushed per encoder enable, popped per channel symbol
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 2'b00;
      end else if (start_go) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (do_push) begin
            fifo_mem[wr_ptr] <= {is_data, enc_bit};
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign dl_in   = {dec_en, do_pop & fifo_head[1], fifo_head[0]};
   assign dl_out  = dline[DEC_LAT-1];
   assign bit_err = dl_out[2] && dl_out[1] && (bus.dec_bit_i != dl_out[0]);

   // Delay line aligning each sent bit with the decoder output DEC_LAT cycles later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEC_LAT; i++) dline[i] <= 3'b000;
      end else if (start_go) begin
         for (int i = 0; i < DEC_LAT; i++) dline[i] <= 3'b000;
      end else begin
         dline[0] <= dl_in;
         for (int i = 1; i < DEC_LAT; i++) dline[i] <= dline[i-1];
      end
   end

   // Any symbol still travelling through the delay line
   always_comb begin
      dl_busy = 1'b0;
      for (int i = 0; i < DEC_LAT; i++) dl_busy = dl_busy | dline[i][2];
   end

   assign drain_idle = !dl_busy && !bus.enc_valid_i && !dec_en && (fifo_cnt == '0);

   // Residual bit error count and completed frame count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         if (start_go)                          bit_cnt <= '0;
         else if (bit_err && bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
         if (state == S_DONE) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign bus.enc_en_o       = enc_en;
   assign bus.enc_bit_o      = enc_bit;
   assign bus.dec_en_o       = dec_en;
   assign bus.ch_sym_o       = ch_sym;
   assign bus.busy_o         = (state != S_IDLE);
   assign bus.done_o         = (state == S_DONE);
   assign bus.chan_err_cnt_o = chan_cnt;
   assign bus.bit_err_cnt_o  = bit_cnt;
   assign bus.frame_cnt_o    = frame_cnt;
   assign bus.state_dbg      = state;
endmodule
